// File: rtl/div_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div_sequencer
// Description : Multi-cycle radix-2 DIV/DIVU unit for the EX stage; one
//               quotient bit per cycle, stalls the pipe, annul/flush aware.
// Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            sign,
    input  logic            annul,
    input  logic [DW-1:0]   opa,
    input  logic [DW-1:0]   opb,
    output logic [2*DW-1:0] result,
    output logic            ready,
    output logic            stall
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_rem;
    logic [DW-1:0]   r_quo;
    logic [DW-1:0]   r_div;
    logic            r_neg_q;
    logic            r_neg_r;

    logic [DW-1:0]   w_abs_a;
    logic [DW-1:0]   w_abs_b;
    logic [DW:0]     w_trial;
    logic [DW-1:0]   w_rem_nxt;
    logic [DW-1:0]   w_quo_nxt;
    logic [DW-1:0]   w_rem_fix;
    logic [DW-1:0]   w_quo_fix;

    assign w_abs_a = (sign && opa[DW-1]) ? (~opa + 1'b1) : opa;
    assign w_abs_b = (sign && opb[DW-1]) ? (~opb + 1'b1) : opb;

    // Trial subtract on the shifted partial remainder; MSB set means borrow.
    assign w_trial   = {r_rem, r_quo[DW-1]} - {1'b0, r_div};
    assign w_rem_nxt = w_trial[DW] ? {r_rem[DW-2:0], r_quo[DW-1]} : w_trial[DW-1:0];
    assign w_quo_nxt = {r_quo[DW-2:0], ~w_trial[DW]};

    assign w_rem_fix = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    assign w_quo_fix = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;

    assign stall = start & ~ready & ~annul;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            result  <= '0;
            ready   <= 1'b0;
        end else if (annul) begin
            r_state <= S_IDLE;
            ready   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    ready <= 1'b0;
                    if (start) begin
                        r_neg_q <= sign & (opa[DW-1] ^ opb[DW-1]);
                        r_neg_r <= sign & opa[DW-1];
                        r_div   <= w_abs_b;
                        r_quo   <= w_abs_a;
                        r_cnt   <= '0;
                        // Divide-by-zero parks the raw dividend in the remainder register.
                        if (opb == '0) begin
                            r_rem   <= opa;
                            r_state <= S_BYZERO;
                        end else begin
                            r_rem   <= '0;
                            r_state <= S_ON;
                        end
                    end
                end
                S_ON: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(DW - 1)) begin
                        result  <= {w_rem_fix, w_quo_fix};
                        ready   <= 1'b1;
                        r_state <= S_END;
                    end
                end
                S_BYZERO: begin
                    result  <= {r_rem, {DW{1'b1}}};
                    ready   <= 1'b1;
                    r_state <= S_END;
                end
                S_END: begin
                    ready   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    ready   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_div_sequencer
// Description : Directed vector bench for div_sequencer (DW = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign;
    logic        annul;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int total = 0;
    int bad   = 0;

    div_sequencer #(.DW(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sign   (sign),
        .annul  (annul),
        .opa    (opa),
        .opb    (opb),
        .result (result),
        .ready  (ready),
        .stall  (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives one op from the current cycle (cycle 0), scrambles operands while busy,
    // checks stall, latency, result and that ready drops the following cycle.
    task automatic run_op(input string nm, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
        int cyc;
        bit got;
        int stall_bad;
        start = 1'b1; sign = s; opa = a; opb = b;
        got = 0; stall_bad = 0; cyc = 0;
        while (!got && cyc < 100) begin
            #1;
            if (ready) begin
                got = 1;
                check({nm, " latency"}, 64'(cyc), 64'(lat));
                check({nm, " result"}, result, exp);
                start = 1'b0;
            end else begin
                if (!stall) stall_bad++;
                @(posedge clk); #1;
                cyc++;
                opa = $urandom();
                opb = $urandom();
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL %s timeout: got no ready expected ready by cycle %0d", nm, lat);
        end
        check({nm, " stall"}, 64'(stall_bad), 64'd0);
        @(posedge clk); #2;
        check({nm, " ready low"}, {63'd0, ready}, 64'd0);
    endtask

    initial begin
        int pulses;
        int first_cyc;
        logic [63:0] first_res;

        vt[0]  = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},       33};
        vt[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
        vt[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h0,        32'h80000000}, 33};
        vt[3]  = '{1'b0, 32'h00001234,   32'd0,        {32'h00001234, 32'hFFFFFFFF}, 2};
        vt[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'h0,        32'hFFFFFFFF}, 33};
        vt[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD}, 33};
        vt[6]  = '{1'b0, 32'hFFFFFFF9,   32'd2,        {32'd1,        32'h7FFFFFFC}, 33};
        vt[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}, 33};
        vt[8]  = '{1'b0, 32'd5,          32'd9,        {32'd5,        32'd0},        33};
        vt[9]  = '{1'b1, 32'hFFFFFFFB,   32'd0,        {32'hFFFFFFFB, 32'hFFFFFFFF}, 2};
        vt[10] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, {32'd0,        32'd1},        33};

        rst = 1'b1; start = 1'b0; sign = 1'b0; annul = 1'b0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset ready", {63'd0, ready}, 64'd0);
        check("reset result", result, 64'd0);
        check("reset stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vt[i].sgn, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);

        // Annul in the middle of an op: no pulse, result keeps the last value.
        start = 1'b1; sign = 1'b0; opa = 32'd100; opb = 32'd7;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        annul = 1'b1;
        #1;
        check("annul stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (ready) pulses++;
            @(posedge clk); #1;
        end
        check("annul no ready", 64'(pulses), 64'd0);
        check("annul result kept", result, {32'd0, 32'd1});
        run_op("after annul", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 33);

        // Back-to-back with start held across the ready cycle.
        start = 1'b1; sign = 1'b0; opa = 32'd9; opb = 32'd2;
        pulses = 0;
        for (int c = 0; c < 71; c++) begin
            #1;
            if (ready) begin
                pulses++;
                if (pulses == 1) begin
                    check("b2b first cycle", 64'(c), 64'd33);
                    check("b2b first result", result, {32'd1, 32'd4});
                    opa = 32'd20; opb = 32'd3;
                end else begin
                    check("b2b second cycle", 64'(c), 64'd67);
                    check("b2b second result", result, {32'd2, 32'd6});
                    start = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        check("b2b pulses", 64'(pulses), 64'd2);

        // Start dropped mid-op without annul: op still completes once.
        start = 1'b1; sign = 1'b0; opa = 32'd20; opb = 32'd3;
        pulses = 0; first_cyc = -1; first_res = '0;
        for (int c = 0; c < 40; c++) begin
            if (c == 5) start = 1'b0;
            #1;
            if (ready) begin
                pulses++;
                if (first_cyc < 0) begin
                    first_cyc = c;
                    first_res = result;
                end
            end
            @(posedge clk); #1;
        end
        check("drop cycle", 64'(first_cyc), 64'd33);
        check("drop result", first_res, {32'd2, 32'd6});
        check("drop pulses", 64'(pulses), 64'd1);

        // Synchronous reset in the middle of an op.
        start = 1'b1; sign = 1'b0; opa = 32'd100; opb = 32'd7;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        #1;
        check("midrst ready", {63'd0, ready}, 64'd0);
        check("midrst result", result, 64'd0);
        @(posedge clk); #1;
        run_op("after reset", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
